// File: rtl/phy_rx_pkg.sv
// Shared constants and lane state encoding for the multilane serial receiver.
package phy_rx_pkg;

    localparam int         BYTE_W = 8;
    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] IDL    = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_e;

endpackage

// File: rtl/phy_rx_lane_align.sv
// One serial lane: bit shifter, COM-based byte alignment and lock, and a single-entry
// holding register whose held flag is released by the top-level word emission.
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              emit,
    output logic [BYTE_W-1:0] hold_byte,
    output logic              held,
    output logic              wr_pend,
    output logic              active
);

    lane_state_e       state_q, state_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        com_cnt_q, com_cnt_d;
    logic              pend_q, pend_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              held_q, held_d;
    logic              byte_done;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sr_d      = {sr_q[BYTE_W-2:0], bit_in};
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        pend_d    = 1'b0;
        hold_d    = hold_q;
        held_d    = held_q;
        // The byte whose last bit is shifted in on this edge is sr_d.
        byte_done = (state_q != SEARCH) && (bit_cnt_q == 3'd7);

        case (state_q)
            SEARCH: begin
                if (sr_d == COM) begin
                    bit_cnt_d = '0;
                    com_cnt_d = 4'd1;
                    state_d   = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (byte_done) begin
                    if (sr_d == COM) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d >= 4'(LOCK_COUNT)) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                pend_d = byte_done && (sr_d != COM) && (sr_d != IDL);
            end
            default: state_d = SEARCH;
        endcase

        // A fresh byte wins over the emission clear, so it stays held for the next word.
        if (pend_q) begin
            hold_d = sr_q;
            held_d = 1'b1;
        end else if (emit) begin
            held_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            pend_q    <= 1'b0;
            // NOTE: the holding byte is reset too, so a partial word never leaks after reset.
            hold_q    <= '0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
            held_q    <= held_d;
        end
    end

    assign hold_byte = hold_q;
    assign held      = held_q;
    assign wr_pend   = pend_q;
    assign active    = (state_q == ACTIVE);

endmodule

// File: rtl/phy_rx_multilane.sv
// Multilane receiver top: waits for a byte on every lane, then emits the unstriped word
// and tracks a sticky overrun flag.
module phy_rx_multilane
    import phy_rx_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic [LANES-1:0]        data_in,
    output logic [BYTE_W*LANES-1:0] data_out,
    output logic                    valid_out,
    output logic [LANES-1:0]        lane_active,
    output logic                    ovf_out
);

    logic [BYTE_W*LANES-1:0] hold_all;
    logic [LANES-1:0]        held;
    logic [LANES-1:0]        wr_pend;
    logic                    emit;

    logic [BYTE_W*LANES-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_rx_lane_align #(
            .LOCK_COUNT(LOCK_COUNT)
        ) u_lane (
            .clk_32f  (clk_32f),
            .reset    (reset),
            .bit_in   (data_in[i]),
            .emit     (emit),
            .hold_byte(hold_all[BYTE_W*i +: BYTE_W]),
            .held     (held[i]),
            .wr_pend  (wr_pend[i]),
            .active   (lane_active[i])
        );
    end

    always_comb begin
        emit    = &held;
        data_d  = emit ? hold_all : data_q;
        valid_d = emit;
        // Overwriting a still-held byte is only an overrun when no emission drains it.
        ovf_d   = ovf_q | (|(wr_pend & held & ~{LANES{emit}}));
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Self-checking bench: per-lane byte streams are serialised into the DUTs and the
// expected words, strobe cycles, lock points and overrun are derived at byte level.
module tb_phy_rx_multilane;
    import phy_rx_pkg::*;

    localparam int MAXL  = 4;
    localparam int MAXC  = 1024;
    localparam int MAXB  = 128;
    localparam int LOCK2 = 4;
    localparam int LOCK4 = 1;

    logic            clk_32f = 1'b0;
    logic            reset;
    logic [MAXL-1:0] din;

    logic [15:0] dout2;
    logic        valid2;
    logic [1:0]  act2;
    logic        ovf2;
    logic [31:0] dout4;
    logic        valid4;
    logic [3:0]  act4;
    logic        ovf4;

    always #5 clk_32f = ~clk_32f;

    phy_rx_multilane #(.LANES(2), .LOCK_COUNT(LOCK2)) u_dut2 (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (din[1:0]),
        .data_out   (dout2),
        .valid_out  (valid2),
        .lane_active(act2),
        .ovf_out    (ovf2)
    );

    phy_rx_multilane #(.LANES(4), .LOCK_COUNT(LOCK4)) u_dut4 (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (din),
        .data_out   (dout4),
        .valid_out  (valid4),
        .lane_active(act4),
        .ovf_out    (ovf4)
    );

    bit         lane_bits [MAXL][MAXC];
    int         lane_len  [MAXL];
    logic [7:0] lane_byte [MAXL][MAXB];
    int         byte_end  [MAXL][MAXB];
    int         byte_n    [MAXL];

    int          got_cyc[$];
    logic [31:0] got_word[$];
    logic [3:0]  act_hist [MAXC];
    logic        ovf_hist [MAXC];

    int total;
    int bad;
    bit sel4;

    // ---------------- stream construction ----------------
    task automatic clear_streams();
        for (int l = 0; l < MAXL; l++) begin
            lane_len[l] = 0;
            byte_n[l]   = 0;
        end
    endtask

    task automatic push_bit(input int l, input bit b);
        lane_bits[l][lane_len[l]] = b;
        lane_len[l]++;
    endtask

    task automatic push_byte(input int l, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) push_bit(l, b[k]);
        lane_byte[l][byte_n[l]] = b;
        byte_end[l][byte_n[l]]  = lane_len[l] - 1;
        byte_n[l]++;
    endtask

    task automatic push_lock(input int l, input int skew);
        for (int k = 0; k < skew; k++) push_bit(l, 1'b0);
        push_byte(l, 8'h00);
        for (int k = 0; k < 4; k++) push_byte(l, COM);
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == COM || b == IDL) b = b ^ 8'h01;
        return b;
    endfunction

    function automatic int stream_len();
        int n;
        n = 0;
        for (int l = 0; l < MAXL; l++) if (lane_len[l] > n) n = lane_len[l];
        return n;
    endfunction

    // ---------------- drive and record ----------------
    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b1;
        din   = '0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    task automatic play(input int n);
        got_cyc.delete();
        got_word.delete();
        for (int c = 0; c < n; c++) begin
            for (int l = 0; l < MAXL; l++) din[l] = (c < lane_len[l]) ? lane_bits[l][c] : 1'b0;
            @(posedge clk_32f);
            #1;
            act_hist[c] = sel4 ? act4 : {2'b00, act2};
            ovf_hist[c] = sel4 ? ovf4 : ovf2;
            if (sel4 ? valid4 : valid2) begin
                got_cyc.push_back(c);
                got_word.push_back(sel4 ? dout4 : {16'h0, dout2});
            end
            @(negedge clk_32f);
        end
    endtask

    // ---------------- reference model checks ----------------
    // Word k is the k-th data byte of every lane (after lock, skipping COM/IDL); it is
    // strobed two edges after the latest lane shifts in that byte's final bit.
    task automatic check_words(input string name);
        int         nl, lock, run, nw, cyc;
        bit         locked;
        int         dcnt [MAXL];
        logic [7:0] dbyte [MAXL][MAXB];
        int         dend [MAXL][MAXB];
        logic [31:0] w;
        nl   = sel4 ? 4 : 2;
        lock = sel4 ? LOCK4 : LOCK2;
        nw   = MAXB;
        for (int l = 0; l < nl; l++) begin
            run     = 0;
            locked  = 1'b0;
            dcnt[l] = 0;
            for (int k = 0; k < byte_n[l]; k++) begin
                if (locked) begin
                    if (lane_byte[l][k] != COM && lane_byte[l][k] != IDL) begin
                        dbyte[l][dcnt[l]] = lane_byte[l][k];
                        dend[l][dcnt[l]]  = byte_end[l][k];
                        dcnt[l]++;
                    end
                end else if (lane_byte[l][k] == COM) begin
                    run++;
                    if (run >= lock) locked = 1'b1;
                end else begin
                    run = 0;
                end
            end
            if (dcnt[l] < nw) nw = dcnt[l];
        end
        total++;
        if (got_cyc.size() != nw) begin
            bad++;
            $display("FAIL %s strobe count: got %0d want %0d", name, got_cyc.size(), nw);
        end
        for (int k = 0; k < nw && k < got_cyc.size(); k++) begin
            w   = '0;
            cyc = 0;
            for (int l = 0; l < nl; l++) begin
                w[8*l +: 8] = dbyte[l][k];
                if (dend[l][k] > cyc) cyc = dend[l][k];
            end
            cyc += 2;
            total++;
            if (got_word[k] !== w || got_cyc[k] != cyc) begin
                bad++;
                $display("FAIL %s word%0d: got %h @%0d want %h @%0d", name, k, got_word[k], got_cyc[k], w, cyc);
            end
        end
    endtask

    task automatic check_lock(input string name, input int n);
        int   nl, lock, run, p;
        logic any;
        nl   = sel4 ? 4 : 2;
        lock = sel4 ? LOCK4 : LOCK2;
        for (int l = 0; l < nl; l++) begin
            run = 0;
            p   = -1;
            for (int k = 0; k < byte_n[l] && p < 0; k++) begin
                if (lane_byte[l][k] == COM) begin
                    run++;
                    if (run >= lock) p = byte_end[l][k];
                end else begin
                    run = 0;
                end
            end
            total++;
            if (p >= 1) begin
                if (act_hist[p-1][l] !== 1'b0 || act_hist[p][l] !== 1'b1 || act_hist[n-1][l] !== 1'b1) begin
                    bad++;
                    $display("FAIL %s lock lane%0d: active before/at/end = %b%b%b want 011",
                             name, l, act_hist[p-1][l], act_hist[p][l], act_hist[n-1][l]);
                end
            end else begin
                any = 1'b0;
                for (int c = 0; c < n; c++) any = any | act_hist[c][l];
                if (any !== 1'b0) begin
                    bad++;
                    $display("FAIL %s nolock lane%0d: active seen %b want 0", name, l, any);
                end
            end
        end
    endtask

    task automatic run_case(input string name);
        int n;
        n = stream_len();
        play(n);
        check_words(name);
        check_lock(name, n);
        total++;
        if (ovf_hist[n-1] !== 1'b0) begin
            bad++;
            $display("FAIL %s ovf: got %b want 0", name, ovf_hist[n-1]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({dout2, valid2, act2, ovf2} !== '0) begin
            bad++;
            $display("FAIL reset2: got %h want 0", {dout2, valid2, act2, ovf2});
        end
        total++;
        if ({dout4, valid4, act4, ovf4} !== '0) begin
            bad++;
            $display("FAIL reset4: got %h want 0", {dout4, valid4, act4, ovf4});
        end
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        clear_streams();
        sel4 = 1'b0;
        push_lock(0, 0);
        push_lock(1, 0);
        push_byte(0, 8'h11);
        push_byte(1, 8'h22);
        for (int l = 0; l < 2; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
        run_case("basic");
    endtask

    task automatic test_align_fail();
        do_reset();
        clear_streams();
        sel4 = 1'b0;
        push_byte(0, 8'h00);
        for (int k = 0; k < 3; k++) push_byte(0, COM);
        push_byte(0, 8'h55);
        for (int k = 0; k < 4; k++) push_byte(0, 8'h00);
        push_lock(1, 0);
        push_byte(1, 8'h66);
        push_byte(1, IDL);
        push_byte(1, IDL);
        run_case("align_fail");
    endtask

    task automatic test_idle();
        do_reset();
        clear_streams();
        sel4 = 1'b0;
        push_lock(0, 0);
        push_lock(1, 0);
        push_byte(0, 8'hA0);
        push_byte(1, 8'hB0);
        push_byte(0, IDL);
        push_byte(1, IDL);
        push_byte(0, 8'hA1);
        push_byte(1, 8'hB1);
        for (int l = 0; l < 2; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
        run_case("idle");
    endtask

    task automatic test_skew();
        do_reset();
        clear_streams();
        sel4 = 1'b0;
        push_lock(0, 0);
        push_lock(1, 3);
        push_byte(0, 8'h33);
        push_byte(1, 8'h44);
        for (int l = 0; l < 2; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
        run_case("skew");
    endtask

    // Fillers sit in the same slot on every lane, so lanes stay within the skew window.
    task automatic build_random(input int nl, input int max_skew);
        int nd, nf;
        for (int l = 0; l < nl; l++) push_lock(l, $urandom_range(max_skew, 0));
        nd = $urandom_range(8, 3);
        for (int d = 0; d < nd; d++) begin
            nf = $urandom_range(2, 0);
            for (int f = 0; f < nf; f++)
                for (int l = 0; l < nl; l++) push_byte(l, ($urandom_range(1, 0) != 0) ? COM : IDL);
            for (int l = 0; l < nl; l++) push_byte(l, rand_data());
        end
        for (int l = 0; l < nl; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            clear_streams();
            sel4 = 1'b0;
            if (it == 0) begin
                push_lock(0, 0);
                push_lock(1, 7);
                for (int d = 0; d < 4; d++)
                    for (int l = 0; l < 2; l++) push_byte(l, rand_data());
                for (int l = 0; l < 2; l++) begin
                    push_byte(l, IDL);
                    push_byte(l, IDL);
                end
            end else begin
                build_random(2, 7);
            end
            run_case("random");
        end
    endtask

    task automatic test_ovf_reset();
        int n, e2;
        do_reset();
        clear_streams();
        sel4 = 1'b0;
        push_lock(0, 0);
        push_lock(1, 0);
        push_byte(0, rand_data() | 8'h01);
        push_byte(1, rand_data() | 8'h01);
        push_byte(0, rand_data());
        push_byte(1, IDL);
        push_byte(0, rand_data());
        push_byte(1, IDL);
        for (int l = 0; l < 2; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
        e2 = byte_end[0][7];
        n  = stream_len();
        play(n);
        check_words("ovf");
        total++;
        if (ovf_hist[e2] !== 1'b0 || ovf_hist[e2+1] !== 1'b1 || ovf_hist[n-1] !== 1'b1) begin
            bad++;
            $display("FAIL ovf sticky: before/set/end = %b%b%b want 011", ovf_hist[e2], ovf_hist[e2+1], ovf_hist[n-1]);
        end
        for (int c = 0; c < 3; c++) begin
            din[0] = 1'($urandom_range(1, 0));
            @(posedge clk_32f);
            @(negedge clk_32f);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dout2 !== 16'h0 || valid2 !== 1'b0) begin
            bad++;
            $display("FAIL midreset data: got %h/%b want 0000/0", dout2, valid2);
        end
        total++;
        if (act2 !== 2'b00 || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL midreset status: active %b ovf %b want 00/0", act2, ovf2);
        end
        @(negedge clk_32f);
        reset = 1'b0;
        clear_streams();
        play(40);
        total++;
        if (got_cyc.size() != 0 || act_hist[39] !== 4'h0) begin
            bad++;
            $display("FAIL post_reset: strobes %0d active %h want 0/0", got_cyc.size(), act_hist[39]);
        end
    endtask

    task automatic test_four_lane();
        do_reset();
        clear_streams();
        sel4 = 1'b1;
        for (int l = 0; l < 4; l++) push_lock(l, 0);
        for (int l = 0; l < 4; l++) push_byte(l, 8'(l + 1));
        for (int l = 0; l < 4; l++) begin
            push_byte(l, IDL);
            push_byte(l, IDL);
        end
        run_case("four_lane");
        total++;
        if (got_word.size() != 1 || got_word[0] !== 32'h04030201) begin
            bad++;
            $display("FAIL four_lane word: got %0d strobes, first %h want 04030201",
                     got_word.size(), (got_word.size() > 0) ? got_word[0] : 32'h0);
        end
        for (int it = 0; it < 3; it++) begin
            do_reset();
            clear_streams();
            build_random(4, 7);
            run_case("four_lane_rand");
        end
        sel4 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel4  = 1'b0;
        din   = '0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_align_fail();
        test_idle();
        test_skew();
        test_random();
        test_ovf_reset();
        test_four_lane();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
